// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 encrypt/decrypt control FSM: sequences init, AD, text and finalisation permutations.
// start->end_o takes 2*PA + (AD+TXT-1)*(1+PB) + 2 cycles; each WAIT state stalls until data_valid_i.
module ascon_ctrl_fsm #(
  parameter int NB_AD_BLOCKS  = 1,
  parameter int NB_TXT_BLOCKS = 4,
  parameter int PA_ROUNDS     = 12,
  parameter int PB_ROUNDS     = 6,
  parameter int BLK_W         = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             data_valid_i,
  input  logic             tag_match_i,
  output logic [3:0]       round_o,
  output logic [BLK_W-1:0] bloc_o,
  output logic             sel_perm_in_o,
  output logic             we_state_o,
  output logic             xor_begin_data_o,
  output logic             xor_begin_key_o,
  output logic             xor_end_key_o,
  output logic             xor_end_lsb_o,
  output logic             sel_cipher_o,
  output logic             we_data_o,
  output logic             we_tag_o,
  output logic             data_ready_o,
  output logic             data_valid_o,
  output logic             busy_o,
  output logic             end_o,
  output logic             auth_ok_o
);

  typedef enum logic [3:0] {
    IDLE, INIT, AD_WAIT, AD_PERM, TXT_WAIT, TXT_PERM, FIN_WAIT, FIN_PERM, TAG
  } state_e;

  localparam logic [3:0]       PA_LAST     = 4'(PA_ROUNDS - 1);
  localparam logic [3:0]       PB_LAST     = 4'(PB_ROUNDS - 1);
  localparam logic [3:0]       PA_BASE     = 4'(12 - PA_ROUNDS);
  localparam logic [3:0]       PB_BASE     = 4'(12 - PB_ROUNDS);
  localparam logic [BLK_W-1:0] AD_LAST     = BLK_W'(NB_AD_BLOCKS - 1);
  localparam logic [BLK_W-1:0] TXT_FIN_IDX = BLK_W'(NB_TXT_BLOCKS - 2);

  state_e           state_q, state_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             mode_q, mode_d;
  logic             auth_q, auth_d;

  logic is_pa, is_pb, rnd_first, rnd_last;

  assign is_pa     = (state_q == INIT) || (state_q == FIN_PERM);
  assign is_pb     = (state_q == AD_PERM) || (state_q == TXT_PERM);
  assign rnd_first = (rnd_q == 4'd0);
  assign rnd_last  = (is_pa && rnd_q == PA_LAST) || (is_pb && rnd_q == PB_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      blk_q   <= '0;
      mode_q  <= 1'b0;
      auth_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      mode_q  <= mode_d;
      auth_q  <= auth_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    mode_d  = mode_q;
    auth_d  = auth_q;
    if (is_pa || is_pb) rnd_d = rnd_last ? 4'd0 : rnd_q + 4'd1;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = INIT;
        mode_d  = mode_i;
        auth_d  = 1'b0;
        rnd_d   = '0;
        blk_d   = '0;
      end
      INIT: if (rnd_last) begin
        if (NB_AD_BLOCKS != 0)       state_d = AD_WAIT;
        else if (NB_TXT_BLOCKS == 1) state_d = FIN_WAIT;
        else                         state_d = TXT_WAIT;
      end
      AD_WAIT:  if (data_valid_i) state_d = AD_PERM;
      AD_PERM: if (rnd_last) begin
        if (blk_q == AD_LAST) begin
          blk_d   = '0;
          state_d = (NB_TXT_BLOCKS == 1) ? FIN_WAIT : TXT_WAIT;
        end else begin
          blk_d   = blk_q + 1'b1;
          state_d = AD_WAIT;
        end
      end
      TXT_WAIT: if (data_valid_i) state_d = TXT_PERM;
      // The final text block is absorbed by FIN_PERM, so leave TXT one block early.
      TXT_PERM: if (rnd_last) begin
        blk_d   = blk_q + 1'b1;
        state_d = (blk_q == TXT_FIN_IDX) ? FIN_WAIT : TXT_WAIT;
      end
      FIN_WAIT: if (data_valid_i) state_d = FIN_PERM;
      FIN_PERM: if (rnd_last) state_d = TAG;
      TAG: begin
        auth_d  = mode_q & tag_match_i;
        state_d = IDLE;
        rnd_d   = '0;
        blk_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    round_o          = '0;
    sel_perm_in_o    = 1'b0;
    we_state_o       = 1'b0;
    xor_begin_data_o = 1'b0;
    xor_begin_key_o  = 1'b0;
    xor_end_key_o    = 1'b0;
    xor_end_lsb_o    = 1'b0;
    sel_cipher_o     = 1'b0;
    we_data_o        = 1'b0;
    we_tag_o         = 1'b0;
    data_ready_o     = 1'b0;
    data_valid_o     = 1'b0;
    end_o            = 1'b0;
    if (is_pa || is_pb) begin
      we_state_o    = 1'b1;
      sel_perm_in_o = rnd_first;
      round_o       = (is_pa ? PA_BASE : PB_BASE) + rnd_q;
    end
    case (state_q)
      INIT: if (rnd_last) begin
        xor_end_key_o = 1'b1;
        xor_end_lsb_o = (NB_AD_BLOCKS == 0);
      end
      AD_WAIT, TXT_WAIT, FIN_WAIT: data_ready_o = 1'b1;
      AD_PERM: begin
        xor_begin_data_o = rnd_first;
        xor_end_lsb_o    = rnd_last && (blk_q == AD_LAST);
      end
      TXT_PERM: if (rnd_first) begin
        xor_begin_data_o = 1'b1;
        we_data_o        = 1'b1;
        data_valid_o     = 1'b1;
        sel_cipher_o     = mode_q;
      end
      FIN_PERM: begin
        if (rnd_first) begin
          xor_begin_data_o = 1'b1;
          xor_begin_key_o  = 1'b1;
          we_data_o        = 1'b1;
          data_valid_o     = 1'b1;
          sel_cipher_o     = mode_q;
        end
        if (rnd_last) begin
          xor_end_key_o = 1'b1;
          we_tag_o      = 1'b1;
        end
      end
      TAG:     end_o = 1'b1;
      default: ;
    endcase
  end

  assign bloc_o    = blk_q;
  assign busy_o    = (state_q != IDLE);
  assign auth_ok_o = auth_q;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: default instance and an (AD=0, TXT=1) instance checked every cycle
// against a segment-queue reference model built from the block/round schedule.
module tb_ascon_ctrl_fsm;
  localparam int PA = 12;
  localparam int PB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, mode, dv, tm;
  logic [3:0] a_round, b_round;
  logic [2:0] a_bloc, b_bloc;
  logic a_sp, a_we, a_xbd, a_xbk, a_xek, a_xel, a_selc, a_wed, a_wet, a_drdy, a_dvo, a_busy, a_end, a_auth;
  logic b_sp, b_we, b_xbd, b_xbk, b_xek, b_xel, b_selc, b_wed, b_wet, b_drdy, b_dvo, b_busy, b_end, b_auth;
  logic [20:0] a_outs, b_outs;

  assign a_outs = {a_round, a_bloc, a_sp, a_we, a_xbd, a_xbk, a_xek, a_xel, a_selc, a_wed, a_wet,
                   a_drdy, a_dvo, a_busy, a_end, a_auth};
  assign b_outs = {b_round, b_bloc, b_sp, b_we, b_xbd, b_xbk, b_xek, b_xel, b_selc, b_wed, b_wet,
                   b_drdy, b_dvo, b_busy, b_end, b_auth};

  ascon_ctrl_fsm u_a (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .mode_i(mode), .data_valid_i(dv), .tag_match_i(tm),
    .round_o(a_round), .bloc_o(a_bloc), .sel_perm_in_o(a_sp), .we_state_o(a_we),
    .xor_begin_data_o(a_xbd), .xor_begin_key_o(a_xbk), .xor_end_key_o(a_xek), .xor_end_lsb_o(a_xel),
    .sel_cipher_o(a_selc), .we_data_o(a_wed), .we_tag_o(a_wet), .data_ready_o(a_drdy),
    .data_valid_o(a_dvo), .busy_o(a_busy), .end_o(a_end), .auth_ok_o(a_auth));

  ascon_ctrl_fsm #(.NB_AD_BLOCKS(0), .NB_TXT_BLOCKS(1)) u_b (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .mode_i(mode), .data_valid_i(dv), .tag_match_i(tm),
    .round_o(b_round), .bloc_o(b_bloc), .sel_perm_in_o(b_sp), .we_state_o(b_we),
    .xor_begin_data_o(b_xbd), .xor_begin_key_o(b_xbk), .xor_end_key_o(b_xek), .xor_end_lsb_o(b_xel),
    .sel_cipher_o(b_selc), .we_data_o(b_wed), .we_tag_o(b_wet), .data_ready_o(b_drdy),
    .data_valid_o(b_dvo), .busy_o(b_busy), .end_o(b_end), .auth_ok_o(b_auth));

  // kind: 0 = wait for a block, 1 = permutation of n rounds, 2 = tag cycle
  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] n;
    logic [2:0] blk;
    logic dat, out, kb, ke, lsb, tg;
  } seg_t;

  seg_t q[$];
  bit   m_busy, m_mode, m_auth, sel, seen_end;
  int   m_r, m_wait_cyc, m_wait_idx, m_ends, m_nad, m_ntxt;
  int   checks, errors, n_dvo, n_selc, n_kl, n_idle, dut_ends;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void add(int k, int n, int b, bit dat, bit out, bit kb, bit ke, bit lsb, bit tg);
    seg_t s;
    s.kind = 2'(k); s.n = 4'(n); s.blk = 3'(b);
    s.dat = dat; s.out = out; s.kb = kb; s.ke = ke; s.lsb = lsb; s.tg = tg;
    q.push_back(s);
  endfunction

  function automatic void build();
    q.delete();
    add(1, PA, 0, 0, 0, 0, 1, m_nad == 0, 0);
    for (int i = 0; i < m_nad; i++) begin
      add(0, 0, i, 0, 0, 0, 0, 0, 0);
      add(1, PB, i, 1, 0, 0, 0, i == m_nad - 1, 0);
    end
    for (int j = 0; j < m_ntxt - 1; j++) begin
      add(0, 0, j, 0, 0, 0, 0, 0, 0);
      add(1, PB, j, 1, 1, 0, 0, 0, 0);
    end
    add(0, 0, m_ntxt - 1, 0, 0, 1, 0, 0, 0);
    add(1, PA, m_ntxt - 1, 1, 1, 1, 1, 0, 1);
    add(2, 0, m_ntxt - 1, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_auth = 0; m_r = 0; m_wait_cyc = 0; m_wait_idx = 0;
    q.delete();
  endfunction

  function automatic void model_step(bit st, bit md, bit d, bit t);
    if (!m_busy) begin
      if (st) begin
        m_busy = 1; m_mode = md; m_auth = 0; m_r = 0; m_wait_idx = 0; m_wait_cyc = 0;
        build();
      end
    end else if (q[0].kind == 2'd0) begin
      if (d) begin q.pop_front(); m_wait_idx++; m_wait_cyc = 0; end
      else m_wait_cyc++;
    end else if (q[0].kind == 2'd1) begin
      if (m_r == int'(q[0].n) - 1) begin q.pop_front(); m_r = 0; end
      else m_r++;
    end else begin
      m_auth = m_mode & t;
      q.pop_front();
      m_busy = 0;
      m_ends++;
    end
  endfunction

  function automatic logic [20:0] expected();
    logic [3:0] r;
    logic [2:0] b;
    logic sp, we, xbd, xbk, xek, xel, selc, wed, wet, drdy, dvo, busy, en;
    bit first, last;
    seg_t s;
    r = '0; b = '0;
    {sp, we, xbd, xbk, xek, xel, selc, wed, wet, drdy, dvo, busy, en} = '0;
    if (m_busy) begin
      s = q[0];
      busy = 1; b = s.blk;
      if (s.kind == 2'd0) drdy = 1;
      else if (s.kind == 2'd1) begin
        first = (m_r == 0);
        last  = (m_r == int'(s.n) - 1);
        we = 1; sp = first;
        r = 4'(12 - int'(s.n) + m_r);
        xbd = first && s.dat; xbk = first && s.kb;
        wed = first && s.out; dvo = first && s.out; selc = first && s.out && m_mode;
        xek = last && s.ke; xel = last && s.lsb; wet = last && s.tg;
      end else en = 1;
    end
    return {r, b, sp, we, xbd, xbk, xek, xel, selc, wed, wet, drdy, dvo, busy, en, m_auth};
  endfunction

  task automatic tick();
    logic [20:0] o;
    #1;
    if (!rst_n) model_reset();
    o = sel ? b_outs : a_outs;
    chk("outs", 32'(o), 32'(expected()));
    seen_end = o[1];
    if (o[1]) dut_ends++;
    if (o[3]) n_dvo++;
    if (o[7]) n_selc++;
    if (o[9] && o[8]) n_kl++;
    if (!o[2]) n_idle++;
    if (rst_n) model_step(start, mode, dv, tm);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input bit md, input bit t, input bit hold, input bit keep, output int lat);
    lat = -1; n_dvo = 0; n_selc = 0; n_kl = 0;
    start = 1; mode = md; tm = t;
    for (int c = 0; c < 500; c++) begin
      if (c > 0) begin start = keep; mode = ~md; end
      dv = 1'b1;
      if (hold && m_busy && q[0].kind == 2'd0 && (m_wait_idx < 2 || q[0].kb) && m_wait_cyc < 5) dv = 1'b0;
      tick();
      if (seen_end) begin lat = c; break; end
    end
    start = 0;
  endtask

  initial begin
    int lat, lat2, e0;
    bit found;
    checks = 0; errors = 0; dut_ends = 0; m_ends = 0;
    sel = 0; m_nad = 1; m_ntxt = 4;
    start = 0; mode = 0; dv = 0; tm = 0;
    rst_n = 1;
    model_reset();
    #2 rst_n = 0;
    @(negedge clk);
    tick(); tick();
    #1;
    chk("reset_outs_a", 32'(a_outs), 32'd0);
    chk("reset_outs_b", 32'(b_outs), 32'd0);
    rst_n = 1;
    tick(); tick();

    // encrypt, defaults, data always present
    run(0, 0, 0, 0, lat);
    chk("enc_latency", lat, 54);
    chk("enc_dvo_pulses", n_dvo, 4);
    chk("enc_sel_cipher", n_selc, 0);
    tick();
    chk("enc_auth", 32'(a_auth), 32'd0);

    // decrypt, tag matches: verdict must persist while idle
    run(1, 1, 0, 0, lat);
    chk("dec_latency", lat, 54);
    chk("dec_sel_cipher", n_selc, 4);
    for (int i = 0; i < 8; i++) begin tm = 1'($urandom); tick(); end
    chk("dec_auth_hold", 32'(a_auth), 32'd1);

    run(1, 0, 0, 0, lat);
    chk("dec_nomatch_sel", n_selc, 4);
    tick();
    chk("dec_nomatch_auth", 32'(a_auth), 32'd0);

    // data withheld 5 cycles in AD_WAIT, first TXT_WAIT and FIN_WAIT
    run(0, 0, 1, 0, lat);
    chk("hold_latency", lat, 69);

    // async reset in the middle of the first text permutation at round 8
    start = 1; mode = 0; dv = 1; tm = 0; found = 0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) start = 0;
      if (m_busy && q[0].kind == 2'd1 && q[0].out && !q[0].kb && q[0].blk == 3'd0 && m_r == 2) begin
        found = 1;
        break;
      end
      tick();
    end
    start = 0;
    #1;
    chk("rst_at_round8", 32'(a_round), 32'd8);
    rst_n = 0;
    #1;
    chk("rst_async_outs", 32'(a_outs), 32'd0);
    e0 = dut_ends;
    tick(); tick(); tick();
    rst_n = 1;
    tick(); tick();
    chk("rst_no_end", dut_ends - e0, 0);
    run(0, 0, 0, 0, lat);
    chk("rst_rerun_latency", lat, 54);

    // start held high throughout: one idle cycle between back-to-back runs
    run(0, 0, 0, 1, lat);
    chk("held_first_latency", lat, 54);
    start = 1; n_idle = 0; lat2 = -1;
    for (int c = 1; c < 200; c++) begin
      tick();
      if (seen_end) begin lat2 = c; break; end
    end
    start = 0;
    chk("held_gap", lat2, 55);
    chk("held_idle_cycles", n_idle, 1);
    tick(); tick();

    // (AD=0, TXT=1) instance
    sel = 1; m_nad = 0; m_ntxt = 1;
    rst_n = 0; tick(); rst_n = 1; tick();
    run(0, 0, 0, 0, lat);
    chk("b_latency", lat, 26);
    chk("b_dvo_pulses", n_dvo, 1);
    chk("b_key_lsb_same_cycle", n_kl, 1);
    run(1, 1, 0, 0, lat);
    chk("b_dec_sel_cipher", n_selc, 1);
    tick();
    chk("b_dec_auth", 32'(b_auth), 32'd1);

    // randomized traffic on each instance, including stray starts and resets
    for (int pass = 0; pass < 2; pass++) begin
      e0 = dut_ends - m_ends;
      for (int i = 0; i < (pass == 0 ? 700 : 1500); i++) begin
        start = ($urandom_range(0, 3) == 0);
        mode  = 1'($urandom);
        dv    = ($urandom_range(0, 2) != 0);
        tm    = 1'($urandom);
        rst_n = ($urandom_range(0, 299) != 0);
        tick();
      end
      rst_n = 1;
      chk("rand_end_count", dut_ends - m_ends, e0);
      sel = 0; m_nad = 1; m_ntxt = 4;
      rst_n = 0; tick(); rst_n = 1; tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
